// File: rtl/swarm_pkg.sv
// Shared types and constants for the swarm node driver: FSM state encoding,
// operand/accumulator widths and the coarse-precision stress threshold.
package swarm_pkg;

    localparam int DATA_W           = 8;
    localparam int ACC_W            = 16;
    localparam int CNT_W            = 8;
    localparam int STRESS_COARSE_TH = 200;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        CAPTURE,
        RESULT
    } state_t;

    // Job op counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/swarm_decay_prescaler.sv
// Free-running divider that emits a registered one-cycle decay_pulse every
// DECAY_DIV clocks, the first one DECAY_DIV-1 cycles after reset release.
module swarm_decay_prescaler #(
    parameter int DECAY_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic decay_pulse
);

    logic [7:0] count;

    // Pulse is registered one count early so it lands on count value DECAY_DIV-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= 8'd0;
            decay_pulse <= 1'b0;
        end else begin
            if (count == 8'(DECAY_DIV - 1)) begin
                count <= 8'd0;
            end else begin
                count <= count + 8'd1;
            end
            decay_pulse <= (count == 8'(DECAY_DIV - 2));
        end
    end

endmodule

// File: rtl/swarm_node_driver.sv
// Drives one swarm node through clear / stream / drain / capture and hands back
// the accumulated result. Define SWARM_THROTTLE_EN to throttle intake on stress.
module swarm_node_driver
    import swarm_pkg::*;
#(
    parameter int DECAY_DIV   = 16,
    parameter int THROTTLE_TH = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              op_last,
    output logic              op_ready,
    output logic              spike_out,
    output logic              decay_pulse,
    output logic              mac_en,
    output logic              mac_clr,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    input  logic [ACC_W-1:0]  mac_in,
    input  logic [DATA_W-1:0] stress_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [DATA_W-1:0] res_stress,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_coarse
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] op_count;
    logic             accept;
    logic             throttle;

`ifdef SWARM_THROTTLE_EN
    assign throttle = (stress_in > 8'(THROTTLE_TH));
`else
    logic unused_throttle;
    assign unused_throttle = (stress_in > 8'(THROTTLE_TH));
    assign throttle        = 1'b0;
`endif

    assign accept = op_valid && op_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (op_valid) next_state = CLEAR;
            CLEAR:   next_state = STREAM;
            STREAM:  if (accept && op_last) next_state = DRAIN;
            DRAIN:   next_state = CAPTURE;
            CAPTURE: next_state = RESULT;
            RESULT:  if (res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        op_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            STREAM:  op_ready = !throttle;
            RESULT:  res_valid = 1'b1;
            default: ;
        endcase
    end

    // Node strobes are registered; mac_clr/spike_out are timed to coincide with CLEAR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mac_clr   <= 1'b0;
            spike_out <= 1'b0;
            mac_en    <= 1'b0;
            data_a    <= '0;
            data_b    <= '0;
            op_count  <= '0;
        end else begin
            mac_clr   <= (next_state == CLEAR);
            spike_out <= (next_state == CLEAR);
            mac_en    <= accept;
            if (accept) begin
                data_a <= op_a;
                data_b <= op_b;
            end
            if (state == CLEAR) begin
                op_count <= '0;
            end else if (accept) begin
                op_count <= sat_inc(op_count);
            end
        end
    end

    // The node's accumulator has absorbed the last product by the CAPTURE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data   <= '0;
            res_stress <= '0;
            res_count  <= '0;
            res_coarse <= 1'b0;
        end else if (state == CAPTURE) begin
            res_data   <= mac_in;
            res_stress <= stress_in;
            res_count  <= op_count;
            res_coarse <= (stress_in > 8'(STRESS_COARSE_TH));
        end
    end

    swarm_decay_prescaler #(
        .DECAY_DIV (DECAY_DIV)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .decay_pulse (decay_pulse)
    );

endmodule

// File: tb/tb_swarm_node_driver.sv
// Scoreboard bench for swarm_node_driver with a behavioural MAC node model;
// honours SWARM_THROTTLE_EN the same way the design does.
module tb_swarm_node_driver;

    localparam int DIV = 16;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  stress;
        logic [7:0]  count;
        logic        coarse;
        int          ops;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_last, op_ready;
    logic        spike_out, decay_pulse, mac_en, mac_clr;
    logic        res_valid, res_ready, res_coarse;
    logic [7:0]  op_a, op_b, data_a, data_b, stress_in, res_stress, res_count;
    logic [15:0] mac_in, res_data;
    logic [15:0] acc = '0;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          n_en = 0, n_clr = 0, n_spike = 0, n_overlap = 0;
    int          dcyc = -1;
    logic [7:0]  job_a[300];
    logic [7:0]  job_b[300];

    always #5 clk = ~clk;

    swarm_node_driver #(
        .DECAY_DIV   (DIV),
        .THROTTLE_TH (200)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_last     (op_last),
        .op_ready    (op_ready),
        .spike_out   (spike_out),
        .decay_pulse (decay_pulse),
        .mac_en      (mac_en),
        .mac_clr     (mac_clr),
        .data_a      (data_a),
        .data_b      (data_b),
        .mac_in      (mac_in),
        .stress_in   (stress_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_stress  (res_stress),
        .res_count   (res_count),
        .res_coarse  (res_coarse)
    );

    // Behavioural node: clear wins, otherwise accumulate the presented pair.
    always @(posedge clk) begin
        if (mac_clr)     acc <= '0;
        else if (mac_en) acc <= acc + data_a * data_b;
    end
    assign mac_in = acc;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Offers n pairs from job_a/job_b; abort_after>0 stops after that many accepts.
    task automatic applyStimulus(input int n, input logic [7:0] stress, input int abort_after);
        logic [15:0] sum = '0;
        int          waited;
        bit          accepted;
        exp_t        e;
        stress_in = stress;
        for (int i = 0; i < n; i++) begin
            if (abort_after > 0 && i == abort_after) begin
                op_valid = 1'b0;
                op_last  = 1'b0;
                return;
            end
            op_valid = 1'b1;
            op_a     = job_a[i];
            op_b     = job_b[i];
            op_last  = (i == n - 1);
            waited   = 0;
            accepted = 1'b0;
            while (!accepted && waited < 100) begin
                @(negedge clk);
                if (op_ready) begin
                    @(posedge clk);
                    #1;
                    accepted = 1'b1;
                end else begin
                    waited++;
                end
            end
            if (!accepted) begin
                checkOutput("accept_timeout", 0, 1);
                op_valid = 1'b0;
                return;
            end
            sum = sum + job_a[i] * job_b[i];
        end
        op_valid = 1'b0;
        op_last  = 1'b0;
        e.data   = sum;
        e.stress = stress;
        e.count  = (n > 255) ? 8'd255 : 8'(n);
        e.coarse = (stress > 8'd200);
        e.ops    = n;
        sb.push_back(e);
    endtask

    task automatic waitDrain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checkOutput("result_timeout", 0, 1);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Result monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_en = 0; n_clr = 0; n_spike = 0; n_overlap = 0;
        end else begin
            n_en    += int'(mac_en);
            n_clr   += int'(mac_clr);
            n_spike += int'(spike_out);
            if (mac_en && mac_clr) n_overlap++;
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("res_data", res_data, mon_e.data);
                    checkOutput("res_count", res_count, mon_e.count);
                    checkOutput("res_stress", res_stress, mon_e.stress);
                    checkOutput("res_coarse", res_coarse, mon_e.coarse);
                    checkOutput("mac_en_pulses", n_en, mon_e.ops);
                    checkOutput("mac_clr_pulses", n_clr, 1);
                    checkOutput("spike_pulses", n_spike, 1);
                    checkOutput("clr_en_overlap", n_overlap, 0);
                end
                n_en = 0; n_clr = 0; n_spike = 0; n_overlap = 0;
            end
        end
    end

    // Decay reference: cycle 0 is the first cycle with rst_n released.
    always @(negedge clk) begin
        if (!rst_n) begin
            dcyc = -1;
        end else begin
            dcyc++;
            checkOutput("decay_pulse", decay_pulse, ((dcyc % DIV) == DIV - 1));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; op_valid = 1'b0; op_last = 1'b0; op_a = '0; op_b = '0;
        res_ready = 1'b1; stress_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        checkOutput("rst_op_ready", op_ready, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_strobes", {mac_clr, spike_out, mac_en}, 0);
        checkOutput("rst_data", {data_a, data_b}, 0);
        checkOutput("rst_res", {res_data, res_count}, 0);
        @(posedge clk);
        #1;

        job_a[0] = 2;  job_b[0] = 3;
        job_a[1] = 4;  job_b[1] = 5;
        job_a[2] = 10; job_b[2] = 10;
        applyStimulus(3, 8'd50, 0);
        waitDrain();

        job_a[0] = 255; job_b[0] = 255;
        applyStimulus(1, 8'd0, 0);
        waitDrain();

        job_a[0] = 1; job_b[0] = 2;
        job_a[1] = 3; job_b[1] = 4;
        applyStimulus(2, 8'd200, 0);
        waitDrain();

`ifdef SWARM_THROTTLE_EN
        stress_in = 8'd201;
        op_valid = 1'b1; op_a = 8'd5; op_b = 8'd6; op_last = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("throttled_ready", op_ready, 0);
        end
        @(posedge clk);
        #1;
        stress_in = 8'd200;
        op_valid  = 1'b0;
        @(negedge clk);
        checkOutput("unthrottled_ready", op_ready, 1);
        @(posedge clk);
        #1;
        job_a[0] = 5; job_b[0] = 6;
        job_a[1] = 7; job_b[1] = 8;
        applyStimulus(2, 8'd200, 0);
        waitDrain();
`else
        applyStimulus(2, 8'd201, 0);
        waitDrain();
`endif

        for (int i = 0; i < 5; i++) begin
            job_a[i] = 8'($urandom_range(0, 255));
            job_b[i] = 8'($urandom_range(0, 255));
        end
        applyStimulus(5, 8'($urandom_range(0, 200)), 0);
        waitDrain();

        for (int i = 0; i < 260; i++) begin
            job_a[i] = 8'd1;
            job_b[i] = 8'd1;
        end
        applyStimulus(260, 8'd7, 0);
        waitDrain();

        res_ready = 1'b0;
        job_a[0] = 3; job_b[0] = 3;
        applyStimulus(1, 8'd10, 0);
        w = 0;
        while (!res_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!res_valid) checkOutput("hold_timeout", 0, 1);
        repeat (5) begin
            checkOutput("hold_valid", res_valid, 1);
            checkOutput("hold_data", res_data, 9);
            checkOutput("hold_count", res_count, 1);
            checkOutput("hold_op_ready", op_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_handshake_valid", res_valid, 0);
        checkOutput("post_handshake_ready", op_ready, 0);
        waitDrain();

        for (int i = 0; i < 4; i++) begin
            job_a[i] = 8'(i + 1);
            job_b[i] = 8'(i + 2);
        end
        applyStimulus(4, 8'd20, 2);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", {op_ready, spike_out, decay_pulse, mac_en, mac_clr, res_valid, res_coarse}, 0);
        checkOutput("reset_res", {res_data, res_count}, 0);
        checkOutput("reset_data", {data_a, data_b, res_stress}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("no_res_after_reset", res_valid, 0);
        end
        @(posedge clk);
        #1;

        job_a[0] = 7; job_b[0] = 8;
        applyStimulus(1, 8'd30, 0);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
